multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for a small RISC-V subset (LW, SW, R-ALU, I-ALU, BEQ/BNE).
// A single FSM sequences each instruction through fetch, decode and execute
// states. Memory states stretch by MEM_WAIT cycles. Control outputs are decoded
// combinationally from the current state, the wait counter and the instruction fields.
module multicycle_control_unit #(
    parameter int unsigned MEM_WAIT = 0,
    parameter bit          EN_BNE   = 1'b1,
    parameter bit          EN_XORI  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] OP,
    input  logic [2:0] Funct3,
    input  logic [6:0] Funct7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic [2:0] ULAControl,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Last wait cycle of a stretched state: the counter counts 0..MEM_WAIT.
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [2:0] wait_q;
    logic       illegal_q, illegal_d;
    logic       wait_last;

    logic       r_legal, i_legal, b_legal;
    logic [2:0] r_ula, i_ula;

    assign wait_last = (wait_q == WAIT_LAST);

    // Instruction legality and ALU operation for the R-type and I-ALU groups.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        r_legal = 1'b0;
        r_ula   = ALU_ADD;
        i_legal = 1'b0;
        i_ula   = ALU_ADD;
        b_legal = 1'b0;

        if (Funct7 == 7'b0000000) begin
            case (Funct3)
                3'b000:  begin r_legal = 1'b1; r_ula = ALU_ADD; end
                3'b111:  begin r_legal = 1'b1; r_ula = ALU_AND; end
                3'b110:  begin r_legal = 1'b1; r_ula = ALU_OR;  end
                3'b010:  begin r_legal = 1'b1; r_ula = ALU_SLT; end
                default: ;
            endcase
        end else if (Funct7 == 7'b0100000 && Funct3 == 3'b000) begin
            r_legal = 1'b1;
            r_ula   = ALU_SUB;
        end

        case (Funct3)
            3'b000:  begin i_legal = 1'b1;    i_ula = ALU_ADD; end
            3'b111:  begin i_legal = 1'b1;    i_ula = ALU_AND; end
            3'b110:  begin i_legal = 1'b1;    i_ula = ALU_OR;  end
            3'b100:  begin i_legal = EN_XORI; i_ula = ALU_XOR; end
            default: ;
        endcase

        b_legal = (Funct3 == 3'b000) || (Funct3 == 3'b001 && EN_BNE);
    end

    // Next-state selection and sticky illegal-instruction detection.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:    if (wait_last) state_d = S_DECODE;
            S_DECODE: begin
                case (OP)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = r_legal ? S_EXECR  : S_FETCH;
                    OP_IALU:      state_d = i_legal ? S_EXECI  : S_FETCH;
                    OP_BRANCH:    state_d = b_legal ? S_BRANCH : S_FETCH;
                    default:      state_d = S_FETCH;
                endcase
                if (state_d == S_FETCH) illegal_d = 1'b1;
            end
            S_MEMADR:   state_d = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (wait_last) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (wait_last) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // State, wait counter and illegal flag; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (state_d != state_q) wait_q <= 3'd0;
            else                    wait_q <= wait_q + 3'd1;
        end
    end

    // Control outputs decoded from the current state; write enables are forced low in reset.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        ResultSrc  = 2'b00;
        ULAControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = wait_last;
                PCWrite   = wait_last;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (OP == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = wait_last;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ULAControl = r_ula;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ULAControl = i_ula;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ULAControl = ALU_SUB;
                PCWrite    = Zero ^ Funct3[0];
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    assign Illegal = illegal_q;
    assign State   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: three differently parameterised
// instances run directed and random instructions; every cycle's outputs are
// compared with a per-instruction expected trace built from the control rules.
module tb_multicycle_control_unit;

    localparam int N = 3;
    localparam int MW [N] = '{0, 2, 3};
    localparam bit EB [N] = '{1'b1, 1'b1, 1'b0};
    localparam bit EX [N] = '{1'b1, 1'b1, 1'b0};

    typedef struct packed {
        logic [3:0] state;
        logic       pcw, irw, rw, mw, adr;
        logic [1:0] asa, asb, imm, res;
        logic [2:0] ula;
        logic       ill;
    } obs_t;

    typedef enum {K_LW, K_SW, K_R, K_I, K_B, K_ILL} kind_t;

    logic       clk = 1'b0;
    logic       rst [N];
    logic [6:0] op [N];
    logic [2:0] f3 [N];
    logic [6:0] f7 [N];
    logic       zero [N];
    logic       pcw [N], irw [N], rw [N], mw [N], adr [N], ill_o [N];
    logic [1:0] asa [N], asb [N], imm [N], res [N];
    logic [2:0] ula [N];
    logic [3:0] st [N];

    bit   ill_m [N];
    obs_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_instr  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        multicycle_control_unit #(
            .MEM_WAIT(MW[g]), .EN_BNE(EB[g]), .EN_XORI(EX[g])
        ) u_dut (
            .clk(clk), .reset(rst[g]), .OP(op[g]), .Funct3(f3[g]), .Funct7(f7[g]),
            .Zero(zero[g]), .PCWrite(pcw[g]), .IRWrite(irw[g]), .RegWrite(rw[g]),
            .MemWrite(mw[g]), .AdrSrc(adr[g]), .ALUSrcA(asa[g]), .ALUSrcB(asb[g]),
            .ImmSrc(imm[g]), .ResultSrc(res[g]), .ULAControl(ula[g]),
            .Illegal(ill_o[g]), .State(st[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, expv);
    endtask

    function automatic obs_t get_obs(input int k);
        obs_t o;
        o = '{state: st[k], pcw: pcw[k], irw: irw[k], rw: rw[k], mw: mw[k], adr: adr[k],
              asa: asa[k], asb: asb[k], imm: imm[k], res: res[k], ula: ula[k], ill: ill_o[k]};
        return o;
    endfunction

    function automatic obs_t blank(input int s, input bit il);
        obs_t e = '0;
        e.state = 4'(s);
        e.ill   = il;
        return e;
    endfunction

    // Expected cycle-by-cycle trace of one instruction, from fetch to the last cycle before the next fetch.
    task automatic gen_trace(input int k, input logic [6:0] o, input logic [2:0] fn3,
                             input logic [6:0] fn7, input logic z);
        kind_t kd = K_ILL;
        logic [2:0] u = 3'b000;
        obs_t e;
        int w = MW[k];
        case (o)
            7'b0000011: kd = K_LW;
            7'b0100011: kd = K_SW;
            7'b0110011: begin
                if (fn7 == 7'h00 && fn3 == 3'b000) begin kd = K_R; u = 3'b000; end
                if (fn7 == 7'h20 && fn3 == 3'b000) begin kd = K_R; u = 3'b001; end
                if (fn7 == 7'h00 && fn3 == 3'b111) begin kd = K_R; u = 3'b010; end
                if (fn7 == 7'h00 && fn3 == 3'b110) begin kd = K_R; u = 3'b011; end
                if (fn7 == 7'h00 && fn3 == 3'b010) begin kd = K_R; u = 3'b101; end
            end
            7'b0010011: begin
                if (fn3 == 3'b000) begin kd = K_I; u = 3'b000; end
                if (fn3 == 3'b111) begin kd = K_I; u = 3'b010; end
                if (fn3 == 3'b110) begin kd = K_I; u = 3'b011; end
                if (fn3 == 3'b100 && EX[k]) begin kd = K_I; u = 3'b100; end
            end
            7'b1100011: if (fn3 == 3'b000 || (fn3 == 3'b001 && EB[k])) kd = K_B;
            default: ;
        endcase

        exp_q.delete();
        for (int i = 0; i <= w; i++) begin
            e = blank(0, ill_m[k]);
            e.asb = 2'b10; e.res = 2'b10;
            e.irw = (i == w); e.pcw = (i == w);
            exp_q.push_back(e);
        end
        e = blank(1, ill_m[k]);
        e.asa = 2'b01; e.asb = 2'b01; e.imm = 2'b10;
        exp_q.push_back(e);
        case (kd)
            K_LW, K_SW: begin
                e = blank(2, ill_m[k]);
                e.asa = 2'b10; e.asb = 2'b01; e.imm = (kd == K_SW) ? 2'b01 : 2'b00;
                exp_q.push_back(e);
                for (int i = 0; i <= w; i++) begin
                    e = blank(kd == K_LW ? 3 : 5, ill_m[k]);
                    e.adr = 1'b1;
                    e.mw  = (kd == K_SW) && (i == w);
                    exp_q.push_back(e);
                end
                if (kd == K_LW) begin
                    e = blank(4, ill_m[k]);
                    e.res = 2'b01; e.rw = 1'b1;
                    exp_q.push_back(e);
                end
            end
            K_R, K_I: begin
                e = blank(kd == K_R ? 6 : 7, ill_m[k]);
                e.asa = 2'b10; e.asb = (kd == K_I) ? 2'b01 : 2'b00; e.ula = u;
                exp_q.push_back(e);
                e = blank(8, ill_m[k]);
                e.rw = 1'b1;
                exp_q.push_back(e);
            end
            K_B: begin
                e = blank(9, ill_m[k]);
                e.asa = 2'b10; e.ula = 3'b001; e.pcw = z ^ fn3[0];
                exp_q.push_back(e);
            end
            default: ill_m[k] = 1'b1;
        endcase
    endtask

    // Hold reset for two cycles, checking the write enables stay low meanwhile.
    task automatic do_reset(input int k);
        rst[k] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check($sformatf("u%0d rst_we", k), {28'd0, pcw[k], irw[k], rw[k], mw[k]}, 32'd0);
            @(posedge clk); #1;
        end
        rst[k]  = 1'b0;
        ill_m[k] = 1'b0;
    endtask

    // Run one instruction from its first fetch cycle; abort_at >= 0 asserts reset in that cycle.
    task automatic do_instr(input int k, input logic [6:0] o, input logic [2:0] fn3,
                            input logic [6:0] fn7, input logic z, input int abort_at);
        gen_trace(k, o, fn3, fn7, z);
        op[k] = o; f3[k] = fn3; f7[k] = fn7; zero[k] = z;
        n_instr++;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("u%0d i%0d op%h c%0d", k, n_instr, o, i), 32'(get_obs(k)), 32'(exp_q[i]));
            if (i == abort_at) begin
                rst[k] = 1'b1;
                #1;
                check($sformatf("u%0d abort_we", k), {28'd0, pcw[k], irw[k], rw[k], mw[k]}, 32'd0);
                @(posedge clk); #1;
                rst[k]   = 1'b0;
                ill_m[k] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_random(input int k, input int count);
        logic [6:0] o, fn7;
        logic [2:0] fn3;
        logic z;
        for (int n = 0; n < count; n++) begin
            fn3 = 3'($urandom_range(0, 7));
            fn7 = 7'h00;
            z   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 6))
                0:       o = 7'b0000011;
                1:       o = 7'b0100011;
                2: begin
                    o = 7'b0110011;
                    case ($urandom_range(0, 2))
                        0:       fn7 = 7'h00;
                        1:       fn7 = 7'h20;
                        default: fn7 = 7'($urandom);
                    endcase
                end
                3, 6:    o = 7'b0010011;
                4:       o = 7'b1100011;
                default: o = 7'($urandom);
            endcase
            do_instr(k, o, fn3, fn7, z, -1);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1; op[k] = '0; f3[k] = '0; f7[k] = '0; zero[k] = 1'b0; ill_m[k] = 1'b0;
        end

        // Instance 0: MEM_WAIT=0, all optional instructions enabled.
        do_reset(0);
        do_instr(0, 7'b0000011, 3'b010, 7'h00, 1'b0, -1);  // LW
        do_instr(0, 7'b0110011, 3'b000, 7'h20, 1'b0, -1);  // SUB
        do_instr(0, 7'b0010011, 3'b100, 7'h00, 1'b0, -1);  // XORI
        do_instr(0, 7'b1100011, 3'b001, 7'h00, 1'b0, -1);  // BNE, Zero=0 -> taken
        do_instr(0, 7'b1100011, 3'b000, 7'h00, 1'b0, -1);  // BEQ, Zero=0 -> not taken
        do_instr(0, 7'b1111111, 3'b000, 7'h00, 1'b0, -1);  // illegal opcode
        do_instr(0, 7'b0110011, 3'b111, 7'h00, 1'b0, -1);  // AND, Illegal stays set
        do_random(0, 40);

        // Instance 1: MEM_WAIT=2.
        do_reset(1);
        do_instr(1, 7'b0100011, 3'b010, 7'h00, 1'b0, -1);  // SW
        do_random(1, 40);

        // Instance 2: MEM_WAIT=3, BNE and XORI disabled.
        do_reset(2);
        do_instr(2, 7'b1100011, 3'b001, 7'h00, 1'b0, -1);  // BNE -> illegal
        do_instr(2, 7'b0010011, 3'b100, 7'h00, 1'b0, -1);  // XORI -> illegal
        do_random(2, 30);
        // SW: fetch is cycles 0..3, decode 4, memadr 5, memwrite starts at 6; abort in its 2nd cycle.
        do_instr(2, 7'b0100011, 3'b010, 7'h00, 1'b0, 7);
        @(negedge clk);
        check("u2 post_abort", {26'd0, st[2], mw[2], ill_o[2]}, 32'd0);
        @(posedge clk); #1;
        // One fetch cycle already consumed: reset the instance again for an aligned restart.
        do_reset(2);
        do_instr(2, 7'b0110011, 3'b010, 7'h00, 1'b0, -1);  // SLT after abort

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
